// File: rtl/button_event_decoder_if.sv
// Signal bundle between the debounced button source and the press decoder.
// btn_n_i/enable_i are levels, not a handshake; the outputs are one-cycle event pulses plus status.
interface button_event_decoder_if;
  logic       btn_n_i;
  logic       enable_i;
  logic       short_o;
  logic       long_o;
  logic       repeat_o;
  logic       held_o;
  logic [7:0] event_cnt_o;
  logic [1:0] state_dbg_o;

  modport master (
    output btn_n_i, enable_i,
    input  short_o, long_o, repeat_o, held_o, event_cnt_o, state_dbg_o
  );

  modport slave (
    input  btn_n_i, enable_i,
    output short_o, long_o, repeat_o, held_o, event_cnt_o, state_dbg_o
  );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced active-low presses into short / long / auto-repeat pulses.
// The hold counter holds the number of pressed samples already seen in the current phase.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int REPEAT_EN     = 1,
  parameter int CNT_W         = 26
) (
  input  logic                   sysclk,
  input  logic                   reset,
  button_event_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    IDLE      = 2'd1,
    PRESSED   = 2'd2,
    LONG_HELD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic             REPEAT_ON   = (REPEAT_EN != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic [7:0]       evt_q, evt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    evt_d    = evt_q;

    if (!bus.enable_i) begin
      state_d = ARM;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ARM: begin
          cnt_d = '0;
          if (bus.btn_n_i) state_d = IDLE;
        end
        IDLE: begin
          if (!bus.btn_n_i) begin
            state_d = PRESSED;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESSED: begin
          if (bus.btn_n_i) begin
            short_d = 1'b1;
            evt_d   = evt_q + 8'd1;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == LONG_LAST) begin
            // This sample is the LONG_CYCLES-th one of the press.
            long_d  = 1'b1;
            evt_d   = evt_q + 8'd1;
            cnt_d   = '0;
            state_d = LONG_HELD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LONG_HELD: begin
          if (bus.btn_n_i) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q == REPEAT_LAST) begin
            repeat_d = REPEAT_ON;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ARM;
          cnt_d   = '0;
        end
      endcase
    end

    held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= ARM;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
      evt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
      evt_q    <= evt_d;
    end
  end

  assign bus.short_o     = short_q;
  assign bus.long_o      = long_q;
  assign bus.repeat_o    = repeat_q;
  assign bus.held_o      = held_q;
  assign bus.event_cnt_o = evt_q;
  assign bus.state_dbg_o = state_q;

endmodule
